note_scheduler: RTL and testbench

Sequences arrow-note spawning during gameplay. It walks a chart ROM of (hit_time, lane_mask) entries and keeps its own song-time base, which advances only while the game controller reports PLAYING and not paused. It issues each note to the arrow renderer LEAD_TICKS before its hit time over a valid/ready handshake. It sits between the game controller outputs (game_active, pause overlay) and the arrow/playfield renderer.

---
 rtl/ddr_pkg.sv | 32 +++
 rtl/tick_prescaler.sv | 47 ++++
 rtl/note_scheduler.sv | 160 ++++++++++++++++
 tb/tb_note_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// ============================================================================
// ddr_pkg : shared types and constants for the note scheduler slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package ddr_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_ISSUE = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int DEF_TIME_W     = 16;
  localparam int DEF_LANES      = 4;
  localparam int DEF_TICK_DIV   = 500000;
  localparam int DEF_LEAD_TICKS = 150;

  // Chart entry layout: {hit_time, lane_mask}
  localparam int LANE_LSB  = 0;
  localparam int TIME_LSB  = DEF_LANES;
  localparam int ENTRY_W   = DEF_TIME_W + DEF_LANES;

  localparam logic [DEF_TIME_W-1:0] END_MARKER = {DEF_TIME_W{1'b1}};

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler : run-gated clock divider emitting a 1-cycle song tick
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tick_prescaler
  import ddr_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_LAST);
  assign tick = run && wrap;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/note_scheduler.sv
// ============================================================================
// note_scheduler : walks the chart ROM and hands each note to the renderer
//                  LEAD_TICKS ahead of its hit time over valid/ready
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module note_scheduler
  import ddr_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int TIME_W     = DEF_TIME_W,
  parameter int ADDR_W     = 8,
  parameter int LANES      = DEF_LANES,
  parameter int LEAD_TICKS = DEF_LEAD_TICKS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    game_active,
  input  logic                    paused,
  input  logic                    restart,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [TIME_W+LANES-1:0] rom_data,
  output logic                    spawn_valid,
  output logic [LANES-1:0]        spawn_lanes,
  input  logic                    spawn_ready,
  output logic [TIME_W-1:0]       song_ticks,
  output logic [ADDR_W-1:0]       notes_issued,
  output logic                    chart_done
);

  localparam logic [TIME_W:0] LEAD_EXT = (TIME_W+1)'(LEAD_TICKS);

  logic run;
  logic tick;
  logic due;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [TIME_W-1:0] entry_time_q, entry_time_d;
  logic [LANES-1:0]  entry_lanes_q, entry_lanes_d;
  logic              spawn_valid_q, spawn_valid_d;
  logic [LANES-1:0]  spawn_lanes_q, spawn_lanes_d;
  logic [TIME_W-1:0] song_ticks_q, song_ticks_d;
  logic [ADDR_W-1:0] notes_issued_q, notes_issued_d;

  assign run = game_active && !paused;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .clear (restart),
    .tick  (tick)
  );

  // Extra bit on both sides so song_ticks + LEAD never wraps
  assign due = ({1'b0, entry_time_q} <= ({1'b0, song_ticks_q} + LEAD_EXT));

  always_comb begin
    state_d        = state_q;
    rom_addr_d     = rom_addr_q;
    entry_time_d   = entry_time_q;
    entry_lanes_d  = entry_lanes_q;
    spawn_valid_d  = spawn_valid_q;
    spawn_lanes_d  = spawn_lanes_q;
    song_ticks_d   = song_ticks_q;
    notes_issued_d = notes_issued_q;

    if (tick && (song_ticks_q != {TIME_W{1'b1}})) begin
      song_ticks_d = song_ticks_q + TIME_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        entry_time_d  = rom_data[TIME_W+LANES-1:LANES];
        entry_lanes_d = rom_data[LANES-1:0];
        state_d       = S_HOLD;
      end
      S_HOLD: begin
        if (entry_time_q == {TIME_W{1'b1}}) begin
          state_d = S_DONE;
        end else if (entry_lanes_q == '0) begin
          if (rom_addr_q == {ADDR_W{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end else if (run && due) begin
          spawn_valid_d = 1'b1;
          spawn_lanes_d = entry_lanes_q;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (spawn_valid_q && spawn_ready) begin
          spawn_valid_d  = 1'b0;
          notes_issued_d = notes_issued_q + ADDR_W'(1);
          // Last ROM slot ends the chart rather than wrapping to address 0
          if (rom_addr_q == {ADDR_W{1'b1}}) begin
            state_d = S_DONE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d        = S_IDLE;
      rom_addr_d     = '0;
      spawn_valid_d  = 1'b0;
      spawn_lanes_d  = '0;
      song_ticks_d   = '0;
      notes_issued_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rom_addr_q     <= '0;
      entry_time_q   <= '0;
      entry_lanes_q  <= '0;
      spawn_valid_q  <= 1'b0;
      spawn_lanes_q  <= '0;
      song_ticks_q   <= '0;
      notes_issued_q <= '0;
    end else begin
      state_q        <= state_d;
      rom_addr_q     <= rom_addr_d;
      entry_time_q   <= entry_time_d;
      entry_lanes_q  <= entry_lanes_d;
      spawn_valid_q  <= spawn_valid_d;
      spawn_lanes_q  <= spawn_lanes_d;
      song_ticks_q   <= song_ticks_d;
      notes_issued_q <= notes_issued_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign spawn_valid  = spawn_valid_q;
  assign spawn_lanes  = spawn_lanes_q;
  assign song_ticks   = song_ticks_q;
  assign notes_issued = notes_issued_q;
  assign chart_done   = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_note_scheduler.sv
// ============================================================================
// tb_note_scheduler : directed self-checking bench for note_scheduler
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_note_scheduler;

  localparam int TIME_W = 16;
  localparam int ADDR_W = 8;
  localparam int LANES  = 4;
  localparam logic [TIME_W-1:0] ENDT = 16'hFFFF;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    game_active = 1'b0;
  logic                    paused = 1'b0;
  logic                    restart = 1'b0;
  logic [ADDR_W-1:0]       rom_addr;
  logic [TIME_W+LANES-1:0] rom_data = '0;
  logic                    spawn_valid;
  logic [LANES-1:0]        spawn_lanes;
  logic                    spawn_ready = 1'b0;
  logic [TIME_W-1:0]       song_ticks;
  logic [ADDR_W-1:0]       notes_issued;
  logic                    chart_done;

  logic [TIME_W+LANES-1:0] rom [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  // Synchronous chart ROM: data follows the address by one cycle
  always @(posedge clock) rom_data <= rom[rom_addr];

  note_scheduler #(
    .TICK_DIV   (4),
    .TIME_W     (TIME_W),
    .ADDR_W     (ADDR_W),
    .LANES      (LANES),
    .LEAD_TICKS (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .game_active  (game_active),
    .paused       (paused),
    .restart      (restart),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .spawn_valid  (spawn_valid),
    .spawn_lanes  (spawn_lanes),
    .spawn_ready  (spawn_ready),
    .song_ticks   (song_ticks),
    .notes_issued (notes_issued),
    .chart_done   (chart_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_chart(input logic [19:0] e0, input logic [19:0] e1, input logic [19:0] e2);
    for (int i = 0; i < 256; i++) rom[i] = {ENDT, 4'h0};
    rom[0] = e0;
    rom[1] = e1;
    rom[2] = e2;
  endtask

  task automatic do_reset();
    game_active = 1'b0;
    paused      = 1'b0;
    restart     = 1'b0;
    spawn_ready = 1'b0;
    reset       = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (spawn_valid) break;
    end
    check(tag, spawn_valid, 1);
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clock);
      if (chart_done) break;
    end
    check(tag, chart_done, 1);
  endtask

  initial begin
    int gap;
    logic stable;
    logic seen;

    // 1: idle with run low
    load_chart({16'd5, 4'b0001}, {16'd5, 4'b0110}, {ENDT, 4'h0});
    do_reset();
    repeat (20) @(negedge clock);
    check("t1_valid", spawn_valid, 0);
    check("t1_lanes", spawn_lanes, 0);
    check("t1_addr", rom_addr, 0);
    check("t1_ticks", song_ticks, 0);
    check("t1_notes", notes_issued, 0);
    check("t1_done", chart_done, 0);
    game_active = 1'b1;
    paused      = 1'b1;
    repeat (12) @(negedge clock);
    check("t1_paused_ticks", song_ticks, 0);

    // 2: two spawns back to back, ready held high
    do_reset();
    game_active = 1'b1;
    spawn_ready = 1'b1;
    wait_valid("t2_valid1", 100);
    check("t2_ticks_at_valid1", song_ticks, 3);
    check("t2_lanes1", spawn_lanes, 4'b0001);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      gap++;
      if (spawn_valid) break;
    end
    check("t2_gap", gap, 4);
    check("t2_lanes2", spawn_lanes, 4'b0110);
    wait_done("t2_done", 50);
    check("t2_notes", notes_issued, 2);
    check("t2_addr", rom_addr, 2);

    // 3: back-pressure holds the offer
    do_reset();
    game_active = 1'b1;
    wait_valid("t3_valid", 100);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!spawn_valid || spawn_lanes != 4'b0001 || rom_addr != 0) stable = 1'b0;
    end
    check("t3_stable", stable, 1);
    spawn_ready = 1'b1;
    @(negedge clock);
    spawn_ready = 1'b0;
    check("t3_valid_dropped", spawn_valid, 0);
    check("t3_notes", notes_issued, 1);
    wait_valid("t3_valid2", 50);
    check("t3_notes_hold", notes_issued, 1);
    check("t3_lanes2", spawn_lanes, 4'b0110);

    // 4: pause freezes song time and issuing
    load_chart({16'd9, 4'b1000}, {ENDT, 4'h0}, {ENDT, 4'h0});
    do_reset();
    game_active = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (song_ticks == 2) break;
    end
    paused = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (spawn_valid) seen = 1'b1;
    end
    check("t4_ticks_frozen", song_ticks, 2);
    check("t4_no_valid", seen, 0);
    paused = 1'b0;
    wait_valid("t4_valid", 100);
    check("t4_ticks_at_valid", song_ticks, 7);
    check("t4_lanes", spawn_lanes, 4'b1000);

    // 5: rest entry is skipped
    load_chart({16'd1, 4'b0000}, {16'd2, 4'b0010}, {ENDT, 4'h0});
    do_reset();
    game_active = 1'b1;
    wait_valid("t5_valid", 100);
    check("t5_lanes", spawn_lanes, 4'b0010);
    check("t5_addr", rom_addr, 1);
    spawn_ready = 1'b1;
    wait_done("t5_done", 50);
    check("t5_notes", notes_issued, 1);
    check("t5_addr_end", rom_addr, 2);

    // 6: restart beats a same-cycle transfer, then async reset mid-offer
    load_chart({16'd5, 4'b0001}, {16'd5, 4'b0110}, {ENDT, 4'h0});
    do_reset();
    game_active = 1'b1;
    wait_valid("t6_valid", 100);
    restart     = 1'b1;
    spawn_ready = 1'b1;
    @(negedge clock);
    restart     = 1'b0;
    spawn_ready = 1'b0;
    check("t6_valid", spawn_valid, 0);
    check("t6_notes", notes_issued, 0);
    check("t6_ticks", song_ticks, 0);
    check("t6_addr", rom_addr, 0);
    check("t6_done", chart_done, 0);
    wait_valid("t6_valid_again", 100);
    #1 reset = 1'b1;
    #1;
    check("t6_async_valid", spawn_valid, 0);
    check("t6_async_ticks", song_ticks, 0);
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
